// File: rtl/scan_sched.sv
// Raster-scan sequencer: steps pan/tilt servo positions over a grid, fires one
// hcsr04 ranging per point and streams a 5-byte record. Option: SCAN_SERPENTINE_EN.
module scan_sched #(
    parameter int POS_LEN    = 8,
    parameter int CAP_LEN    = 16,
    parameter int CNT_LEN    = 22,
    parameter int SETTLE_CYC = 1_000_000,
    parameter int MEAS_TO    = 2_500_000,
    parameter int POS_RST    = 150
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [POS_LEN-1:0] x_min,
    input  logic [POS_LEN-1:0] x_max,
    input  logic [POS_LEN-1:0] x_step,
    input  logic [POS_LEN-1:0] y_min,
    input  logic [POS_LEN-1:0] y_max,
    input  logic [POS_LEN-1:0] y_step,
    output logic [POS_LEN-1:0] pos_x,
    output logic [POS_LEN-1:0] pos_y,
    output logic               hc_en,
    input  logic               hc_done,
    input  logic [CAP_LEN-1:0] hc_len,
    output logic [7:0]         tx_data,
    output logic               tx_send,
    input  logic               tx_busy,
    output logic               busy,
    output logic               frame_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_MOVE, S_SETTLE, S_TRIG, S_MEAS, S_SEND, S_SEND_WAIT, S_STEP
    } state_t;

    localparam logic [CNT_LEN-1:0] SETTLE_LAST = CNT_LEN'(SETTLE_CYC - 1);
    localparam logic [CNT_LEN-1:0] MEAS_LAST   = CNT_LEN'(MEAS_TO - 1);
    localparam logic [POS_LEN-1:0] POS_INIT    = POS_LEN'(POS_RST);

    state_t             state_q;
    logic [POS_LEN-1:0] xmin_q, xmax_q, xstep_q, ymax_q, ystep_q;
    logic [POS_LEN-1:0] x_q, y_q, pos_x_q, pos_y_q;
    logic [CNT_LEN-1:0] cnt_q;
    logic [CAP_LEN-1:0] len_q;
    logic [2:0]         idx_q;
    logic               stop_pend_q;
    logic               hc_en_q, tx_send_q, busy_q, frame_done_q;
    logic [7:0]         tx_data_q;
`ifdef SCAN_SERPENTINE_EN
    logic               row_odd_q;
`endif

    logic [POS_LEN:0]   x_up_d, y_up_d;
    logic [POS_LEN-1:0] x_d, y_d;
    logic               row_end_d, frame_end_d;
    logic [7:0]         rec_byte;

    // Next grid point, computed one bit wider so a step never wraps through 0.
    always_comb begin
        x_up_d    = {1'b0, x_q} + {1'b0, xstep_q};
        y_up_d    = {1'b0, y_q} + {1'b0, ystep_q};
        x_d       = x_q;
        y_d       = y_q;
        row_end_d = 1'b0;
`ifdef SCAN_SERPENTINE_EN
        if (row_odd_q) begin
            if (x_q == xmin_q)
                row_end_d = 1'b1;
            else if ({1'b0, x_q} < ({1'b0, xmin_q} + {1'b0, xstep_q}))
                x_d = xmin_q;
            else
                x_d = x_q - xstep_q;
        end else if (x_up_d > {1'b0, xmax_q}) begin
            row_end_d = 1'b1;
        end else begin
            x_d = x_up_d[POS_LEN-1:0];
        end
`else
        if (x_up_d > {1'b0, xmax_q}) begin
            row_end_d = 1'b1;
            x_d       = xmin_q;
        end else begin
            x_d = x_up_d[POS_LEN-1:0];
        end
`endif
        if (row_end_d)
            y_d = y_up_d[POS_LEN-1:0];
        frame_end_d = row_end_d && (y_up_d > {1'b0, ymax_q});
    end

    always_comb begin
        case (idx_q)
            3'd0:    rec_byte = 8'h0F;
            3'd1:    rec_byte = 8'(x_q);
            3'd2:    rec_byte = 8'(y_q);
            3'd3:    rec_byte = len_q[15:8];
            default: rec_byte = len_q[7:0];
        endcase
    end

    // Byte handshake: tx_send holds tx_data steady until tx_busy is seen high
    // (byte accepted); the next byte is offered only after tx_busy returns low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            xmin_q       <= '0;
            xmax_q       <= '0;
            xstep_q      <= '0;
            ymax_q       <= '0;
            ystep_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            pos_x_q      <= POS_INIT;
            pos_y_q      <= POS_INIT;
            cnt_q        <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            stop_pend_q  <= 1'b0;
            hc_en_q      <= 1'b0;
            tx_send_q    <= 1'b0;
            tx_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef SCAN_SERPENTINE_EN
            row_odd_q    <= 1'b0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            if (stop && (state_q inside {S_MOVE, S_SETTLE, S_TRIG, S_MEAS, S_STEP})) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                hc_en_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !stop) begin
                            xmin_q      <= x_min;
                            xmax_q      <= (x_max < x_min) ? x_min : x_max;
                            xstep_q     <= (x_step == '0) ? POS_LEN'(1) : x_step;
                            ymax_q      <= (y_max < y_min) ? y_min : y_max;
                            ystep_q     <= (y_step == '0) ? POS_LEN'(1) : y_step;
                            x_q         <= x_min;
                            y_q         <= y_min;
                            stop_pend_q <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= S_MOVE;
`ifdef SCAN_SERPENTINE_EN
                            row_odd_q   <= 1'b0;
`endif
                        end
                    end
                    S_MOVE: begin
                        pos_x_q <= x_q;
                        pos_y_q <= y_q;
                        cnt_q   <= '0;
                        state_q <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (cnt_q == SETTLE_LAST) begin
                            cnt_q   <= '0;
                            hc_en_q <= 1'b1;
                            state_q <= S_TRIG;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_TRIG: begin
                        if (!hc_done) begin
                            cnt_q   <= '0;
                            state_q <= S_MEAS;
                        end
                    end
                    S_MEAS: begin
                        if (hc_done || (cnt_q == MEAS_LAST)) begin
                            len_q   <= hc_done ? hc_len : '1;
                            hc_en_q <= 1'b0;
                            idx_q   <= '0;
                            state_q <= S_SEND;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_SEND: begin
                        if (stop)
                            stop_pend_q <= 1'b1;
                        if (tx_busy) begin
                            tx_send_q <= 1'b0;
                            state_q   <= S_SEND_WAIT;
                        end else begin
                            tx_data_q <= rec_byte;
                            tx_send_q <= 1'b1;
                        end
                    end
                    S_SEND_WAIT: begin
                        if (stop)
                            stop_pend_q <= 1'b1;
                        if (!tx_busy) begin
                            if (idx_q == 3'd4) begin
                                idx_q <= '0;
                                if (stop_pend_q || stop) begin
                                    busy_q  <= 1'b0;
                                    state_q <= S_IDLE;
                                end else begin
                                    state_q <= S_STEP;
                                end
                            end else begin
                                idx_q   <= idx_q + 1'b1;
                                state_q <= S_SEND;
                            end
                        end
                    end
                    S_STEP: begin
                        if (frame_end_d) begin
                            frame_done_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= S_IDLE;
                        end else begin
                            x_q     <= x_d;
                            y_q     <= y_d;
                            state_q <= S_MOVE;
`ifdef SCAN_SERPENTINE_EN
                            if (row_end_d)
                                row_odd_q <= ~row_odd_q;
`endif
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign hc_en      = hc_en_q;
    assign tx_data    = tx_data_q;
    assign tx_send    = tx_send_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_sched.sv
// Bench for scan_sched: serial_t and hcsr04 behavioural models, a grid-walk
// reference model producing expected bytes/points, directed and random frames.
module tb_scan_sched;
    localparam int SETTLE   = 8;
    localparam int MEAS_TO  = 64;
    localparam int SER_BUSY = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] x_min = '0, x_max = '0, x_step = '0;
    logic [7:0] y_min = '0, y_max = '0, y_step = '0;
    logic [7:0] pos_x, pos_y, tx_data;
    logic       hc_en, tx_send, busy, frame_done;
    logic       hc_done = 1'b0;
    logic       tx_busy = 1'b0;
    logic [15:0] hc_len = '0;

    always #5 clk = ~clk;

    scan_sched #(.SETTLE_CYC(SETTLE), .MEAS_TO(MEAS_TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .x_min(x_min), .x_max(x_max), .x_step(x_step),
        .y_min(y_min), .y_max(y_max), .y_step(y_step),
        .pos_x(pos_x), .pos_y(pos_y), .hc_en(hc_en), .hc_done(hc_done),
        .hc_len(hc_len), .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
        .busy(busy), .frame_done(frame_done)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] pts_q[$];
    logic [7:0]  rx_q[$];
    logic [15:0] mp_q[$];
    int          en_q[$];
    int          fd_cnt = 0;
    int          ser_cnt = 0;
    int          hc_cnt = 0;
    int          hc_delay = 20;
    logic        hc_never = 1'b0;
    logic        hc_en_prev = 1'b0;
    int          en_run = 0;
    logic [15:0] exp_len = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // serial_t model: accepts a byte on tx_send, then stays busy SER_BUSY cycles
    always @(negedge clk) begin
        if (ser_cnt != 0) ser_cnt--;
        else if (tx_send) begin
            rx_q.push_back(tx_data);
            ser_cnt = SER_BUSY;
        end
        tx_busy = (ser_cnt != 0);
    end

    // hcsr04 model plus trace of measurement positions and enable lengths
    always @(negedge clk) begin
        if (!hc_en) begin
            hc_cnt  = 0;
            hc_done = 1'b0;
        end else if (!hc_never) begin
            if (hc_cnt >= hc_delay) hc_done = 1'b1;
            else hc_cnt++;
        end
        if (hc_en && !hc_en_prev) mp_q.push_back({pos_x, pos_y});
        if (hc_en) en_run++;
        else if (hc_en_prev) begin
            en_q.push_back(en_run);
            en_run = 0;
        end
        hc_en_prev = hc_en;
        if (frame_done) fd_cnt++;
    end

    // Reference: walk the grid with plain integer loops
    task automatic build_model(input int xmn, input int xmx, input int xst,
                               input int ymn, input int ymx, input int yst);
        int sx, sy, hx, hy;
        int xs[$];
`ifdef SCAN_SERPENTINE_EN
        int row;
        row = 0;
`endif
        sx = (xst == 0) ? 1 : xst;
        sy = (yst == 0) ? 1 : yst;
        hx = (xmx < xmn) ? xmn : xmx;
        hy = (ymx < ymn) ? ymn : ymx;
        pts_q.delete();
        exp_q.delete();
        for (int y = ymn; y <= hy; y += sy) begin
            xs.delete();
            for (int x = xmn; x <= hx; x += sx) xs.push_back(x);
`ifdef SCAN_SERPENTINE_EN
            if (row % 2 == 1) begin
                int x;
                x = xs[$];
                xs.delete();
                xs.push_back(x);
                while (x != xmn) begin
                    x = (x - sx < xmn) ? xmn : x - sx;
                    xs.push_back(x);
                end
            end
            row++;
`endif
            foreach (xs[i]) begin
                pts_q.push_back({8'(xs[i]), 8'(y)});
                exp_q.push_back(8'h0F);
                exp_q.push_back(8'(xs[i]));
                exp_q.push_back(8'(y));
                exp_q.push_back(exp_len[15:8]);
                exp_q.push_back(exp_len[7:0]);
            end
        end
    endtask

    task automatic clr();
        rx_q.delete();
        mp_q.delete();
        en_q.delete();
        fd_cnt = 0;
    endtask

    task automatic begin_frame(input int xmn, input int xmx, input int xst,
                               input int ymn, input int ymx, input int yst);
        clr();
        x_min = 8'(xmn); x_max = 8'(xmx); x_step = 8'(xst);
        y_min = 8'(ymn); y_max = 8'(ymx); y_step = 8'(yst);
        build_model(xmn, xmx, xst, ymn, ymx, yst);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, busy, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk({tag, "_byte"}, rx_q[i], exp_q[i]);
        chk({tag, "_npts"}, mp_q.size(), pts_q.size());
        for (int i = 0; i < pts_q.size() && i < mp_q.size(); i++)
            chk({tag, "_pos"}, mp_q[i], pts_q[i]);
        chk({tag, "_frame_done"}, fd_cnt, 1);
    endtask

    task automatic pick_axis(output int mn, output int mx, output int st);
        int s;
        st = $urandom_range(0, 12);
        s  = (st == 0) ? 1 : st;
        mn = ($urandom_range(0, 1) == 1) ? $urandom_range(200, 255) : $urandom_range(0, 255);
        mx = mn + s * $urandom_range(0, 3) + $urandom_range(0, s - 1);
        if (mx > 255) mx = 255;
        if ($urandom_range(0, 4) == 0 && mn > 0) mx = $urandom_range(0, mn - 1);
    endtask

    initial begin
        int k, n, xa, xb, xc, ya, yb, yc;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_pos_x", pos_x, 150);
        chk("rst_pos_y", pos_y, 150);
        chk("rst_hc_en", hc_en, 0);
        chk("rst_tx_send", tx_send, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);

        // single row, fixed echo length, settle latency from start
        hc_delay = 20; hc_never = 1'b0; hc_len = 16'h1234; exp_len = 16'h1234;
        begin_frame(10, 30, 10, 5, 5, 1);
        k = 1;
        while (!hc_en && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("first_trig_latency", k, SETTLE + 2);
        wait_idle("t1", 3000);
        check_frame("t1");

        // near-overflow grid
        hc_len = 16'hBEEF; exp_len = 16'hBEEF; hc_delay = 7;
        begin_frame(0, 250, 100, 0, 200, 200);
        wait_idle("t2", 4000);
        check_frame("t2");

        // echo never returns: timeout length, scan continues, zero step
        hc_never = 1'b1; hc_len = 16'h5A5A; exp_len = 16'hFFFF;
        begin_frame(3, 4, 1, 7, 7, 0);
        wait_idle("t3", 3000);
        check_frame("t3");
        chk("t3_nen", en_q.size(), 2);
        foreach (en_q[i]) chk("t3_en_len", en_q[i], MEAS_TO + 1);
        hc_never = 1'b0;

        // random grids
        for (int t = 0; t < 5; t++) begin
            pick_axis(xa, xb, xc);
            pick_axis(ya, yb, yc);
            hc_delay = $urandom_range(1, 40);
            hc_len   = 16'($urandom);
            exp_len  = hc_len;
            begin_frame(xa, xb, xc, ya, yb, yc);
            wait_idle("rnd", 8000);
            check_frame("rnd");
        end

        // stop while settling
        hc_delay = 5; hc_len = 16'h0102; exp_len = 16'h0102;
        begin_frame(10, 30, 10, 5, 5, 1);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_settle_busy", busy, 0);
        chk("stop_settle_hc_en", hc_en, 0);
        repeat (40) @(negedge clk);
        chk("stop_settle_nbytes", rx_q.size(), 0);
        chk("stop_settle_npts", mp_q.size(), 0);
        chk("stop_settle_fd", fd_cnt, 0);

        // stop during byte 2: record completes, no further point
        begin_frame(10, 20, 10, 5, 5, 1);
        n = 0;
        while (rx_q.size() < 3 && n < 600) begin
            @(negedge clk);
            n++;
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("stop_send", 500);
        chk("stop_send_nbytes", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("stop_send_byte", rx_q[i], exp_q[i]);
        chk("stop_send_npts", mp_q.size(), 1);
        chk("stop_send_fd", fd_cnt, 0);

        // start and stop together
        clr();
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (20) @(negedge clk);
        chk("start_stop_busy", busy, 0);
        chk("start_stop_nbytes", rx_q.size(), 0);

        // start while busy with changed bounds is ignored
        begin_frame(10, 20, 10, 5, 5, 1);
        repeat (30) @(negedge clk);
        x_min = 8'd100; x_max = 8'd200; y_min = 8'd40; y_max = 8'd60;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("restart", 3000);
        check_frame("restart");

`ifdef SCAN_SERPENTINE_EN
        begin_frame(0, 20, 10, 0, 1, 1);
        wait_idle("serp", 4000);
        check_frame("serp");
`endif

        // reset in the middle of a record
        begin_frame(10, 30, 10, 5, 5, 1);
        n = 0;
        while (!tx_send && n < 300) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_tx_send", tx_send, 0);
        chk("midrst_tx_data", tx_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_hc_en", hc_en, 0);
        chk("midrst_frame_done", frame_done, 0);
        chk("midrst_pos_x", pos_x, 150);
        chk("midrst_pos_y", pos_y, 150);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
